// File: rtl/result_streamer_if.sv
// Memory B read port and host-side valid/ready stream for result_streamer.
// The master modport is the streamer side.
interface result_streamer_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 8
) ();
  logic              enable_b_rd;
  logic [ADDR_W-1:0] dir_B_rd;
  logic [DATA_W-1:0] data_b;
  logic [DATA_W-1:0] m_data;
  logic              m_valid;
  logic              m_ready;
  logic              m_last;

  modport master (
    output enable_b_rd, dir_B_rd, m_data, m_valid, m_last,
    input  data_b, m_ready
  );

  modport slave (
    input  enable_b_rd, dir_B_rd, m_data, m_valid, m_last,
    output data_b, m_ready
  );
endinterface

// File: rtl/result_streamer.sv
// Drains one frame from result memory B onto a valid/ready stream through a
// 2-entry prefetch buffer, hiding the 1-cycle read latency of memory B.
module result_streamer #(
  parameter int DATA_W    = 16,
  parameter int ADDR_W    = 8,
  parameter int FRAME_LEN = 192
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  output logic                busy,
  output logic                frame_done,
  result_streamer_if.master   bus
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  // One extra bit so FRAME_LEN == 2**ADDR_W still terminates.
  localparam logic [ADDR_W:0] LEN  = (ADDR_W+1)'(FRAME_LEN);
  localparam logic [ADDR_W:0] LAST = (ADDR_W+1)'(FRAME_LEN - 1);

  state_t            r_state;
  logic [ADDR_W:0]   r_rd_cnt;
  logic [ADDR_W:0]   r_out_cnt;
  logic              r_inflight;
  logic [1:0]        r_count;
  logic [DATA_W-1:0] r_buf [2];
  logic              r_busy;
  logic              r_frame_done;

  logic              w_valid;
  logic              w_pop;
  logic              w_issue;
  logic [2:0]        w_level;

  always_comb begin
    w_valid = (r_count != 2'd0);
    w_pop   = w_valid & bus.m_ready;
    // Occupancy after this edge, counting the read already in flight.
    w_level = 3'(r_count) + 3'(r_inflight) - 3'(w_pop);
    w_issue = (r_state == RUN) && (r_rd_cnt < LEN) && (w_level <= 3'd1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= IDLE;
      r_rd_cnt     <= '0;
      r_out_cnt    <= '0;
      r_inflight   <= 1'b0;
      r_count      <= '0;
      r_buf[0]     <= '0;
      r_buf[1]     <= '0;
      r_busy       <= 1'b0;
      r_frame_done <= 1'b0;
    end else begin
      r_inflight <= w_issue;
      if (w_issue) r_rd_cnt <= r_rd_cnt + 1'b1;
      if (w_pop)   r_out_cnt <= r_out_cnt + 1'b1;

      // Head always lives in r_buf[0]; pops shift the second entry forward.
      case ({r_inflight, w_pop})
        2'b10: begin
          r_buf[r_count[0]] <= bus.data_b;
          r_count           <= r_count + 2'd1;
        end
        2'b01: begin
          r_buf[0] <= r_buf[1];
          r_count  <= r_count - 2'd1;
        end
        2'b11: begin
          if (r_count == 2'd1) begin
            r_buf[0] <= bus.data_b;
          end else begin
            r_buf[0] <= r_buf[1];
            r_buf[1] <= bus.data_b;
          end
        end
        default: ;
      endcase

      case (r_state)
        IDLE: begin
          if (start) begin
            r_state   <= RUN;
            r_rd_cnt  <= '0;
            r_out_cnt <= '0;
            r_busy    <= 1'b1;
          end
        end
        RUN: begin
          if (w_pop && (r_out_cnt == LAST)) begin
            r_state      <= DONE;
            r_frame_done <= 1'b1;
          end
        end
        DONE: begin
          r_state      <= IDLE;
          r_frame_done <= 1'b0;
          r_busy       <= 1'b0;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  always_comb begin
    busy            = r_busy;
    frame_done      = r_frame_done;
    bus.enable_b_rd = w_issue;
    bus.dir_B_rd    = r_rd_cnt[ADDR_W-1:0];
    bus.m_valid     = w_valid;
    bus.m_data      = r_buf[0];
    bus.m_last      = w_valid && (r_out_cnt == LAST);
  end

endmodule

// File: tb/tb_result_streamer.sv
// Bench for result_streamer: a scoreboard of expected beats filled per frame
// from a memory B model, a negedge monitor, and directed timing scenarios.
module tb_result_streamer;
  localparam int DW = 16;
  localparam int AW = 8;
  localparam int FL = 192;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic start_a = 1'b0;
  logic start_b = 1'b0;
  logic busy_a, done_a, busy_b, done_b;

  always #5 clk = ~clk;

  result_streamer_if #(.DATA_W(DW), .ADDR_W(AW)) bus_a ();
  result_streamer_if #(.DATA_W(DW), .ADDR_W(AW)) bus_b ();

  result_streamer #(.DATA_W(DW), .ADDR_W(AW), .FRAME_LEN(FL)) dut_a (
    .clk(clk), .reset(reset), .start(start_a), .busy(busy_a),
    .frame_done(done_a), .bus(bus_a.master)
  );

  result_streamer #(.DATA_W(DW), .ADDR_W(AW), .FRAME_LEN(1)) dut_b (
    .clk(clk), .reset(reset), .start(start_b), .busy(busy_b),
    .frame_done(done_b), .bus(bus_b.master)
  );

  logic [DW-1:0] mem [1 << AW];

  always @(posedge clk) begin
    if (bus_a.enable_b_rd) bus_a.data_b <= mem[bus_a.dir_B_rd];
    if (bus_b.enable_b_rd) bus_b.data_b <= mem[bus_b.dir_B_rd];
  end

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [DW-1:0] d;
    logic          l;
  } beat_t;

  beat_t exp_q[$];
  beat_t b, held;

  int cyc = 0;
  int t0 = 0;
  int rel_m;
  int first_v, done_rel, busy_first, busy_last, busy_cnt;
  int n_done = 0;
  int issued_frame = 0;
  int nxt_addr = 0;
  int outstanding = 0;
  int pops_frame = 0;
  bit done_flag = 1'b0;
  bit hold_pend = 1'b0;

  always @(posedge clk) cyc++;

  // Monitor / scoreboard for the FRAME_LEN=192 instance.
  always @(negedge clk) begin
    if (reset) begin
      hold_pend = 1'b0;
    end else begin
      rel_m = cyc - t0;
      check("outstanding_le_2", (outstanding <= 2) ? 1 : 0, 1);
      if (hold_pend) begin
        check("hold_valid", 32'(bus_a.m_valid), 1);
        check("hold_data", 32'(bus_a.m_data), 32'(held.d));
        check("hold_last", 32'(bus_a.m_last), 32'(held.l));
      end
      hold_pend = bus_a.m_valid && !bus_a.m_ready;
      held.d = bus_a.m_data;
      held.l = bus_a.m_last;
      if (bus_a.m_valid && first_v < 0) first_v = rel_m;
      if (busy_a) begin
        if (busy_first < 0) busy_first = rel_m;
        busy_last = rel_m;
        busy_cnt++;
      end
      if (bus_a.enable_b_rd) begin
        check("rd_addr", 32'(bus_a.dir_B_rd), nxt_addr);
        nxt_addr++;
        issued_frame++;
        outstanding++;
      end
      if (bus_a.m_valid && bus_a.m_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_beat", 32'(bus_a.m_data), -1);
        end else begin
          b = exp_q.pop_front();
          check("beat_data", 32'(bus_a.m_data), 32'(b.d));
          check("beat_last", 32'(bus_a.m_last), 32'(b.l));
        end
        pops_frame++;
        outstanding--;
      end
      if (done_a) begin
        done_rel  = rel_m;
        n_done++;
        done_flag = 1'b1;
        check("issued_per_frame", issued_frame, FL);
        check("sb_empty_at_done", exp_q.size(), 0);
        issued_frame = 0;
        nxt_addr     = 0;
      end
    end
  end

  // Caller is at posedge+#1 of the cycle that becomes cycle 0; returns in cycle 1.
  task automatic start_a_frame();
    start_a    = 1'b1;
    t0         = cyc;
    first_v    = -1;
    busy_first = -1;
    busy_last  = -1;
    busy_cnt   = 0;
    done_flag  = 1'b0;
    pops_frame = 0;
    for (int i = 0; i < FL; i++) exp_q.push_back('{mem[i], (i == FL - 1)});
    @(posedge clk); #1;
    start_a = 1'b0;
  endtask

  task automatic wait_done_a(input int limit, input bit rnd);
    for (int k = 0; k < limit && !done_flag; k++) begin
      @(posedge clk); #1;
      if (rnd) bus_a.m_ready = 1'($urandom_range(0, 1));
    end
    if (!done_flag) check("frame_done_timeout", 0, 1);
    bus_a.m_ready = 1'b1;
  endtask

  task automatic check_a_zero(input string tag);
    check({tag, "_busy"},  32'(busy_a), 0);
    check({tag, "_en"},    32'(bus_a.enable_b_rd), 0);
    check({tag, "_dir"},   32'(bus_a.dir_B_rd), 0);
    check({tag, "_data"},  32'(bus_a.m_data), 0);
    check({tag, "_valid"}, 32'(bus_a.m_valid), 0);
    check({tag, "_last"},  32'(bus_a.m_last), 0);
    check({tag, "_done"},  32'(done_a), 0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n0;
    for (int i = 0; i < (1 << AW); i++) mem[i] = DW'(i + 'h100);
    bus_a.m_ready = 1'b1;
    bus_b.m_ready = 1'b1;
    first_v = -1; done_rel = -1; busy_first = -1; busy_last = -1; busy_cnt = 0;

    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check_a_zero("rst");
    check("rst_b_busy",  32'(busy_b), 0);
    check("rst_b_valid", 32'(bus_b.m_valid), 0);
    check("rst_b_en",    32'(bus_b.enable_b_rd), 0);

    // Basic frame with continuous ready
    @(posedge clk); #1;
    start_a_frame();
    wait_done_a(400, 1'b0);
    check("basic_first_valid", first_v, 3);
    check("basic_done_cycle", done_rel, FL + 3);
    check("basic_busy_first", busy_first, 1);
    check("basic_busy_last", busy_last, FL + 3);
    check("basic_busy_cnt", busy_cnt, FL + 3);
    check("basic_beats", pops_frame, FL);
    check("basic_busy_after", 32'(busy_a), 0);

    // Random backpressure
    start_a_frame();
    wait_done_a(3000, 1'b1);
    check("rand_beats", pops_frame, FL);

    // Stall with full buffer: ready low in cycles 2..11
    start_a_frame();
    @(posedge clk); #1;
    bus_a.m_ready = 1'b0;
    for (int k = 2; k < 12; k++) begin
      @(negedge clk);
      check("stall_en", 32'(bus_a.enable_b_rd), (k == 2) ? 1 : 0);
      @(posedge clk); #1;
      if (k == 11) check("stall_reads_issued", issued_frame, 2);
    end
    bus_a.m_ready = 1'b1;
    @(negedge clk);
    check("stall_resume_en", 32'(bus_a.enable_b_rd), 1);
    check("stall_resume_dir", 32'(bus_a.dir_B_rd), 2);
    wait_done_a(400, 1'b0);
    check("stall_beats", pops_frame, FL);

    // Extra starts during RUN (cycles 10, 100) and DONE (cycle FL+3)
    n0 = n_done;
    start_a_frame();
    for (int k = 2; k <= FL + 3; k++) begin
      @(posedge clk); #1;
      start_a = (k == 10 || k == 100 || k == FL + 3);
    end
    @(posedge clk); #1;
    start_a = 1'b0;
    check("busy_start_done_cycle", done_rel, FL + 3);
    check("busy_start_one_frame", n_done - n0, 1);
    start_a_frame();
    @(negedge clk);
    check("restart_en", 32'(bus_a.enable_b_rd), 1);
    check("restart_dir", 32'(bus_a.dir_B_rd), 0);
    wait_done_a(400, 1'b0);
    check("restart_beats", pops_frame, FL);

    // Reset after 50 accepted words
    start_a_frame();
    for (int k = 0; k < 500 && pops_frame < 50; k++) begin
      @(posedge clk); #1;
    end
    check("mid_reset_reached_50", pops_frame, 50);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    exp_q.delete();
    nxt_addr = 0; issued_frame = 0; outstanding = 0; hold_pend = 1'b0;
    @(negedge clk);
    check_a_zero("midrst");
    @(posedge clk); #1;
    start_a_frame();
    wait_done_a(400, 1'b0);
    check("post_reset_beats", pops_frame, FL);
    check("total_frames", n_done, 6);

    // FRAME_LEN = 1 instance
    start_b = 1'b1;
    @(posedge clk); #1;
    start_b = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      check("small_en", 32'(bus_b.enable_b_rd), (k == 1) ? 1 : 0);
      if (k == 1) check("small_dir", 32'(bus_b.dir_B_rd), 0);
      check("small_valid", 32'(bus_b.m_valid), (k == 3) ? 1 : 0);
      check("small_last", 32'(bus_b.m_last), (k == 3) ? 1 : 0);
      if (k == 3) check("small_data", 32'(bus_b.m_data), 'h100);
      check("small_done", 32'(done_b), (k == 4) ? 1 : 0);
      check("small_busy", 32'(busy_b), (k <= 4) ? 1 : 0);
      @(posedge clk); #1;
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
